// File: rtl/seq_approx_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, approximate low rows.
// Optional DIV_RUNTIME_EXACT_EN adds exact_mode to force exact cells per operation.
module seq_approx_divider #(
    parameter int D_W         = 8,
    parameter int Q_W         = 8,
    parameter int APPROX_ROWS = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [Q_W+D_W-1:0] n,
    input  logic [D_W-1:0]     d,
`ifdef DIV_RUNTIME_EXACT_EN
    input  logic               exact_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [Q_W-1:0]     q,
    output logic [D_W-1:0]     r,
    output logic               div_by_zero
);

    localparam int N_W = Q_W + D_W;
    localparam int I_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t         state_q, state_d;
    logic [Q_W-1:0] nlo_q, nlo_d;
    logic [D_W-1:0] d_q, d_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic [I_W-1:0] idx_q, idx_d;
    logic [Q_W-1:0] qacc_q, qacc_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [Q_W-1:0] q_q, q_d;
    logic [D_W-1:0] r_q, r_d;
    logic           dz_q, dz_d;
    logic           exact_q, exact_d;

    logic           nbit;
    logic [D_W:0]   t;
    logic [D_W-1:0] diff;
    logic [D_W-1:0] rem_nx;
    logic [Q_W-1:0] qacc_nx;
    logic           use_apx;
    logic           bw;
    logic           x;
    logic           y;
    logic           qbit;

    // One trial-subtract row through the borrow chain, LSB first.
    always_comb begin
        nbit = 1'b0;
        for (int k = 0; k < Q_W; k++) begin
            if (idx_q == I_W'(k)) nbit = nlo_q[k];
        end
        t       = {rem_q, nbit};
        use_apx = (int'(idx_q) < APPROX_ROWS) && !exact_q;
        bw      = 1'b0;
        diff    = '0;
        x       = 1'b0;
        y       = 1'b0;
        for (int j = 0; j < D_W; j++) begin
            x = t[j];
            y = d_q[j];
            if (use_apx) begin
                diff[j] = (~x & y & ~bw) | (x & ~y & bw) | (x & y);
                bw      = ~bw;
            end else begin
                diff[j] = x ^ y ^ bw;
                bw      = (~x & y) | (~(x ^ y) & bw);
            end
        end
        qbit    = t[D_W] | ~bw;
        rem_nx  = qbit ? diff : t[D_W-1:0];
        qacc_nx = qacc_q;
        for (int k = 0; k < Q_W; k++) begin
            if (idx_q == I_W'(k)) qacc_nx[k] = qbit;
        end
    end

    always_comb begin
        state_d = state_q;
        nlo_d   = nlo_q;
        d_d     = d_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        qacc_d  = qacc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        exact_d = exact_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nlo_d   = n[Q_W-1:0];
                    d_d     = d;
                    rem_d   = n[N_W-1:Q_W];
                    idx_d   = I_W'(Q_W - 1);
                    qacc_d  = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef DIV_RUNTIME_EXACT_EN
                    exact_d = exact_mode;
`else
                    exact_d = 1'b0;
`endif
                end
            end
            CALC: begin
                rem_d  = rem_nx;
                qacc_d = qacc_nx;
                if (idx_q == '0) begin
                    q_d     = qacc_nx;
                    r_d     = rem_nx;
                    dz_d    = (d_q == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nlo_q   <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            qacc_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nlo_q   <= nlo_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            qacc_q  <= qacc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            exact_q <= exact_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Bench for seq_approx_divider: exact (APPROX_ROWS=0) and approximate (6) instances.
// A latency/result model is compared every cycle, plus literal directed checks.
module tb_seq_approx_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n = '0;
    logic [7:0]  d = '0;
    logic        em = 1'b0;
    logic        ex_in;

    logic        busy0, done0, dz0, busy1, done1, dz1;
    logic [7:0]  q0, r0, q1, r1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

`ifdef DIV_RUNTIME_EXACT_EN
    assign ex_in = em;
`else
    assign ex_in = 1'b0;
`endif

    seq_approx_divider #(.D_W(8), .Q_W(8), .APPROX_ROWS(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .d(d),
`ifdef DIV_RUNTIME_EXACT_EN
        .exact_mode(em),
`endif
        .busy(busy0), .done(done0), .q(q0), .r(r0), .div_by_zero(dz0)
    );

    seq_approx_divider #(.D_W(8), .Q_W(8), .APPROX_ROWS(6)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .d(d),
`ifdef DIV_RUNTIME_EXACT_EN
        .exact_mode(em),
`endif
        .busy(busy1), .done(done1), .q(q1), .r(r1), .div_by_zero(dz1)
    );

    // Restoring division: exact rows use integer compare/subtract,
    // approximate rows apply the approximate cell equation column by column.
    function automatic logic [15:0] model(input int nn, input int dd,
                                          input int ar, input bit ex);
        int rem, qq, t, lo, df, b, xx, yy, dj, qb;
        bit bo;
        rem = (nn >> 8) & 255;
        qq  = 0;
        for (int i = 7; i >= 0; i--) begin
            t  = rem * 2 + ((nn >> i) & 1);
            lo = t & 255;
            if (i < ar && !ex) begin
                b  = 0;
                df = 0;
                for (int j = 0; j < 8; j++) begin
                    xx = (lo >> j) & 1;
                    yy = (dd >> j) & 1;
                    dj = ((xx == 0 && yy == 1 && b == 0) ||
                          (xx == 1 && yy == 0 && b == 1) ||
                          (xx == 1 && yy == 1)) ? 1 : 0;
                    df = df | (dj << j);
                    b  = 1 - b;
                end
                bo = (b == 1);
            end else begin
                df = (lo - dd) & 255;
                bo = (lo < dd);
            end
            qb  = (t >= 256 || !bo) ? 1 : 0;
            rem = (qb == 1) ? df : lo;
            qq  = qq | (qb << i);
        end
        return {qq[7:0], rem[7:0]};
    endfunction

    int          mcnt = 0;
    logic        mb = 0, md = 0, mz = 0, pz = 0;
    logic [7:0]  mq0 = 0, mr0 = 0, mq1 = 0, mr1 = 0;
    logic [15:0] p0 = 0, p1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0; mb <= 0; md <= 0; mz <= 0; pz <= 0;
            mq0 <= 0; mr0 <= 0; mq1 <= 0; mr1 <= 0;
            p0 <= 0; p1 <= 0;
        end else begin
            md <= 0;
            if (mcnt == 0) begin
                if (start) begin
                    mcnt <= 8;
                    mb   <= 1;
                    p0   <= model(int'(n), int'(d), 0, ex_in);
                    p1   <= model(int'(n), int'(d), 6, ex_in);
                    pz   <= (d == 0);
                end
            end else begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mb <= 0;
                    md <= 1;
                    {mq0, mr0} <= p0;
                    {mq1, mr1} <= p1;
                    mz <= pz;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy0", 32'(busy0), 32'(mb));
        chk("busy1", 32'(busy1), 32'(mb));
        chk("done0", 32'(done0), 32'(md));
        chk("done1", 32'(done1), 32'(md));
        chk("q0", 32'(q0), 32'(mq0));
        chk("r0", 32'(r0), 32'(mr0));
        chk("q1", 32'(q1), 32'(mq1));
        chk("r1", 32'(r1), 32'(mr1));
        chk("dz0", 32'(dz0), 32'(mz));
        chk("dz1", 32'(dz1), 32'(mz));
    end

    task automatic go(input logic [15:0] nv, input logic [7:0] dv);
        start = 1'b1;
        n     = nv;
        d     = dv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called one negedge after the start edge; returns cycles to done.
    task automatic wait_done(output int k, output int nb);
        bit seen;
        k    = 1;
        nb   = busy0 ? 1 : 0;
        seen = done0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (busy0) nb++;
            seen = done0;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout: no done after %0d cycles", k);
        end
    endtask

    logic [15:0] tv;
    int          k, nb;
    logic [15:0] vn[6] = '{16'hFFFF, 16'h0100, 16'h7FFF, 16'h00FF, 16'hABCD, 16'h0000};
    logic [7:0]  vd[6] = '{8'h01,    8'h03,    8'hFF,    8'h10,    8'h5A,    8'h09};

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_q", 32'(q0), 0);
        chk("rst_r", 32'(r0), 0);
        chk("rst_dz", 32'(dz0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        tv = model(1000, 7, 0, 0);   chk("m_1000_7", 32'(tv), 32'h8E06);
        tv = model(16'h1234, 0, 0, 0); chk("m_dz", 32'(tv), 32'hFF34);
        tv = model(50, 5, 0, 0);     chk("m_50_5", 32'(tv), 32'h0A00);
        tv = model(255, 16, 0, 0);   chk("m_255_16", 32'(tv), 32'h0F0F);
        tv = model(1000, 7, 6, 0);   chk("m_apx_hi", 32'(tv[15:14]), 2);
        tv = model(1000, 7, 8, 1);   chk("m_exact_force", 32'(tv), 32'h8E06);

        go(16'd1000, 8'd7);
        wait_done(k, nb);
        chk("lat", 32'(k), 9);
        chk("busy_cycles", 32'(nb), 8);
        chk("d_q0", 32'(q0), 142);
        chk("d_r0", 32'(r0), 6);
        chk("d_dz0", 32'(dz0), 0);
        chk("d_q1_hi", 32'(q1[7:6]), 2);

        go(16'h1234, 8'd0);
        wait_done(k, nb);
        chk("dz_q0", 32'(q0), 8'hFF);
        chk("dz_r0", 32'(r0), 8'h34);
        chk("dz_flag", 32'(dz0), 1);

        go(16'd1000, 8'd7);
        @(negedge clk);
        @(negedge clk);
        go(16'd50, 8'd5);
        wait_done(k, nb);
        chk("ign_q0", 32'(q0), 142);
        chk("ign_r0", 32'(r0), 6);
        go(16'd50, 8'd5);
        wait_done(k, nb);
        chk("b2b_lat", 32'(k), 9);
        chk("b2b_q0", 32'(q0), 10);
        chk("b2b_r0", 32'(r0), 0);

        go(16'd1000, 8'd7);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy0), 0);
        chk("ar_done", 32'(done0), 0);
        chk("ar_q", 32'(q0), 0);
        chk("ar_r", 32'(r0), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ar_nodone", 32'(done0), 0);
        go(16'd255, 8'd16);
        wait_done(k, nb);
        chk("pr_q0", 32'(q0), 15);
        chk("pr_r0", 32'(r0), 15);

        for (int i = 0; i < 6; i++) begin
            go(vn[i], vd[i]);
            wait_done(k, nb);
        end
        chk("ov_q0", 32'(q0), 8'h00);
        chk("ov_r0", 32'(r0), 8'h00);

`ifdef DIV_RUNTIME_EXACT_EN
        em = 1'b1;
        go(16'd1000, 8'd7);
        em = 1'b0;
        wait_done(k, nb);
        chk("ex_q1", 32'(q1), 142);
        chk("ex_r1", 32'(r1), 6);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
